// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the round-robin mux arbiter:
//   arb_state_t : arbiter FSM state (IDLE / GRANT)
//   ARB_MAX_N   : widest request vector rr_pick can scan
//   sel_width() : select width for an N-lane mux (never below 1)
//   rr_pick()   : round-robin winner search starting at a pointer
// -----------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_MAX_N = 64;

  // Select width for an n-lane mux; a 1-lane mux still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  // Scan req from ptr upward modulo n and return the first set index.
  // With no request set the pointer itself is returned; callers only use
  // the result when at least one request is present.
  function automatic int unsigned rr_pick(input logic [ARB_MAX_N-1:0] req,
                                          input int unsigned          ptr,
                                          input int unsigned          n);
    int unsigned idx;
    int unsigned win;
    logic        found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < ARB_MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) begin
          idx = idx - n;
        end else begin
          idx = idx;
        end
        if (!found && req[idx[5:0]]) begin
          win   = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_muxN.sv
// -----------------------------------------------------------------------------
// muxN
// Plain N-to-1 single-bit multiplexer.
//   x   : N data lanes
//   sel : lane index; an index beyond N-1 yields 0
//   y   : x[sel]
// -----------------------------------------------------------------------------
module muxN #(
  parameter int N = 8
) (
  input  logic [N-1:0]         x,
  input  logic [$clog2(N)-1:0] sel,
  output logic                 y
);

  // Lane selection; out-of-range selects (non power-of-two N) read as 0.
  always_comb begin
    y = 1'b0;
    if (int'(sel) < N) begin
      y = x[sel];
    end else begin
      y = 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter owning the select of a shared muxN. One requester is
// granted at a time, for at most BURST consecutive cycles before re-arbitration.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   lock : (only with MUXARB_LOCK_EN defined) holder may exceed BURST
//   req  : level-sensitive request per requester
//   x    : data lanes, lane i belongs to requester i
//   gnt  : registered one-hot grant, zero when idle
//   sel  : registered mux select (current or last grant)
//   busy : registered, high while a grant is active
//   y    : x[sel] gated to 0 when not busy
// Optional feature macro: MUXARB_LOCK_EN.
// -----------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MUXARB_LOCK_EN
  input  logic                 lock,
`endif
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         x,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic                 y
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          busy_q, busy_d;

  logic          any_req_s;
  logic          hold_req_s;
  logic          lock_s;
  logic          expire_s;
  logic          take_s;
  logic [SW-1:0] win_s;
  logic [N-1:0]  win_onehot_s;
  logic          y_raw_s;

`ifdef MUXARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  assign any_req_s    = |req;
  assign hold_req_s   = req[sel_q];
  assign win_s        = SW'(rr_pick(ARB_MAX_N'(req), 32'(ptr_q), 32'(N)));
  assign win_onehot_s = {{(N-1){1'b0}}, 1'b1} << win_s;
  // Lock only suspends the burst limit; it never keeps a dropped request.
  assign expire_s     = (cnt_q == BURST_C) && !lock_s;

  // Next-state logic: decide whether a new winner is taken this edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    take_s  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (any_req_s) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      GRANT: begin
        if (!hold_req_s) begin
          // Early release: hand over in the same edge when anyone else waits.
          if (any_req_s) begin
            take_s = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (!expire_s) begin
          // Saturating count so a locked holder parks at BURST.
          if (cnt_q != BURST_C) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          // Burst spent: a lone holder simply wins again via rr_pick.
          take_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (take_s) begin
      state_d = GRANT;
      gnt_d   = win_onehot_s;
      sel_d   = win_s;
      busy_d  = 1'b1;
      cnt_d   = CNT_ONE;
      if (win_s == LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_s + SW'(1);
      end
    end else begin
      ptr_d = ptr_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  muxN #(.N(N)) u_mux (
    .x   (x),
    .sel (sel_q),
    .y   (y_raw_s)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  // Idle gating keeps stale lane data off the output.
  assign y    = busy_q & y_raw_s;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed scenarios for mux_rr_arbiter (N=8, BURST=4) followed by random
// traffic compared against a requester-level round-robin model.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  localparam int N     = 8;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         lock_v;
  logic [N-1:0] req;
  logic [N-1:0] x;
  logic [N-1:0] gnt;
  logic [2:0]   sel;
  logic         busy;
  logic         y;

  int total = 0;
  int bad   = 0;

  // Model: who holds the grant (-1 = nobody), where the search starts,
  // how long the holder has had it, and the last select value.
  int m_hold = -1;
  int m_ptr  = 0;
  int m_cnt  = 0;
  int m_sel  = 0;

  logic [7:0] xv = 8'b10101100;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .BURST(BURST)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef MUXARB_LOCK_EN
    .lock (lock_v),
`endif
    .req  (req),
    .x    (x),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand the grant to the first requester at or after m_ptr (mod N).
  function automatic void pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i[2:0]]) begin
        m_hold = i;
        m_sel  = i;
        m_ptr  = (i + 1) % N;
        m_cnt  = 1;
        return;
      end
    end
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_hold = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    end else if (m_hold < 0) begin
      if (req != 8'h00) pick();
    end else if (!req[m_hold[2:0]]) begin
      if (req != 8'h00) pick();
      else m_hold = -1;
    end else if (m_cnt < BURST) begin
      m_cnt++;
    end else if (!lock_v) begin
      pick();
    end
  endfunction

  task automatic check_model();
    logic [7:0] eg;
    logic       ey;
    eg = (m_hold < 0) ? 8'h00 : (8'h01 << m_hold);
    ey = (m_hold < 0) ? 1'b0 : x[m_sel[2:0]];
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_sel", 32'(sel), m_sel);
    chk("model_busy", 32'(busy), (m_hold < 0) ? 32'd0 : 32'd1);
    chk("model_y", 32'(y), 32'(ey));
  endtask

  // One clock: inputs were set before the edge; check 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    int idx;
    rst = 1'b1; req = 8'hFF; x = xv; lock_v = 1'b0;

    // Reset held for two cycles with every request set.
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_y", 32'(y), 32'h0);
    end

    // Single requester 2: continuous grant across burst expiries.
    rst = 1'b0; req = 8'b00000100;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("single_gnt", 32'(gnt), 32'h04);
      chk("single_sel", 32'(sel), 32'd2);
      chk("single_y", 32'(y), 32'd1);
    end
    req = 8'h00;
    cyc();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_sel_hold", 32'(sel), 32'd2);
    chk("idle_y", 32'(y), 32'h0);

    // Full contention from a fresh pointer: each index holds 4 cycles.
    rst = 1'b1; cyc(); rst = 1'b0; req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      cyc();
      idx = (c / 4) % 8;
      chk("rr_sel", 32'(sel), idx);
      chk("rr_y", 32'(y), 32'(xv[idx[2:0]]));
    end

    // Early release of requester 3 hands straight to requester 5.
    rst = 1'b1; cyc(); rst = 1'b0; req = 8'b00101000;
    cyc();
    chk("early_gnt3", 32'(gnt), 32'h08);
    chk("early_sel3", 32'(sel), 32'd3);
    cyc();
    req = 8'b00100000;
    cyc();
    chk("early_gnt5", 32'(gnt), 32'h20);
    chk("early_sel5", 32'(sel), 32'd5);
    chk("early_busy", 32'(busy), 32'd1);

    // Reset in the third cycle of a grant to requester 6.
    rst = 1'b1; cyc(); rst = 1'b0; req = 8'b01000000;
    cyc(); cyc();
    chk("mid_gnt6", 32'(gnt), 32'h40);
    rst = 1'b1;
    cyc();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_sel", 32'(sel), 32'h0);
    rst = 1'b0; req = 8'hFF;
    cyc();
    chk("mid_first_gnt", 32'(gnt), 32'h01);

`ifdef MUXARB_LOCK_EN
    // Lock holds requester 0 past the burst limit.
    rst = 1'b1; cyc(); rst = 1'b0; req = 8'hFF; lock_v = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("lock_sel0", 32'(sel), 32'd0);
    end
    lock_v = 1'b0;
    cyc();
    chk("unlock_sel1", 32'(sel), 32'd1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0) begin
        req = 8'($urandom);
        if ($urandom_range(0, 3) == 0) req = 8'h00;
      end
`ifdef MUXARB_LOCK_EN
      lock_v = ($urandom_range(0, 2) == 0);
`endif
      x = 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
